sync_fifo_flex: RTL
===================

# sync_fifo_flex

Single-clock, parametrised FIFO that generalises the team's dual-clock FIFO for same-domain buffering. It adds the following:
- any (non-power-of-two) depth;
- a fill count;
- programmable almost-full/almost-empty thresholds;
- a selectable read mode: standard registered read, or first-word-fall-through (FWFT).

It sits between same-clock producer/consumer stages and keeps the existing error-pulse convention for rejected accesses.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer)
- AF_TH, 14, almost-full threshold; constraint 1 ≤ AF_TH ≤ DEPTH
- AE_TH, 2, almost-empty threshold; constraint 0 ≤ AE_TH < AF_TH
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through
- CNT_W, clog2(DEPTH+1), width of count_o (derived; not overridden)

Ports:
- clk_i  in  1  single clock; all logic on posedge
- rst_i  in  1  reset, synchronous, active-high
- wr_en_i  in  1  write request
- wdata_i  in  WIDTH  write data
- rd_en_i  in  1  read request (pop)
- rdata_o  out  WIDTH  read data
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- almost_full_o  out  1  count ≥ AF_TH
- almost_empty_o  out  1  count ≤ AE_TH
- count_o  out  CNT_W  current occupancy, 0..DEPTH
- wr_error_o  out  1  one-cycle pulse: a write was rejected
- rd_error_o  out  1  one-cycle pulse: a read was rejected

## Operation
- All acceptance decisions use the registered state at the clock edge.
- Read acceptance: rd_acc = rd_en_i & (count ≠ 0).
- Write acceptance: wr_acc = wr_en_i & ((count ≠ DEPTH) | rd_acc).
  - When full, a simultaneous read and write are both accepted; count stays DEPTH.
- When empty, a simultaneous read and write: the read is rejected (rd_error_o pulses) and the write is accepted.
- Storage and pointers:
  - Storage is mem[DEPTH], with wr_ptr and rd_ptr in range 0..DEPTH-1.
  - Each pointer increments on its accept and wraps from DEPTH-1 to 0. No power-of-two assumption.
- Count update: count_next = count + wr_acc − rd_acc, held in an explicit register.
- All flags are decoded from the registered count.
- Rejected write: memory, wr_ptr and count are unchanged; wr_error_o = 1 for exactly the next cycle.
- Rejected read: rd_ptr, count and rdata_o are unchanged; rd_error_o = 1 for exactly the next cycle.
- Standard mode (FWFT = 0):
  - rdata_o is a register loaded with mem[rd_ptr] on rd_acc.
  - It holds its value otherwise, including across writes and rejected reads.
- FWFT mode (FWFT = 1):
  - rdata_o = mem[rd_ptr] whenever empty_o = 0, and 0 when empty_o = 1.
  - rd_en_i acknowledges (pops) the displayed word.
- Reset, applied at any time, including mid-burst:
  - pointers and count go to 0; pending operations are discarded;
  - memory contents are not cleared.

## Timing
- Reset values: rdata_o = 0, full_o = 0, empty_o = 1, almost_full_o = 0, almost_empty_o = 1, count_o = 0, wr_error_o = 0, rd_error_o = 0.
  - rst_i wins over wr_en_i/rd_en_i in the same cycle.
- Flags and count_o change one cycle after the accepting edge. There are no combinational paths from the enables to the flags.
- Standard-mode read latency: rd_en_i sampled at edge N gives valid rdata_o after edge N, usable in cycle N+1.
- FWFT write-to-visible latency into an empty FIFO: write at edge N makes rdata_o and empty_o = 0 valid after edge N.
- FWFT pop: head advances after the accepting edge.
- Error pulses: registered, asserted in the cycle following the rejected request, one cycle per rejected request. Back-to-back rejects give a continuous high.
- Throughput: one write and one read per cycle sustained, including at full and at wrap-around.

## Structure
- Shared package/header fifo_pkg holds:
  - the clog2 constant function;
  - read-mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
- It is reused by the dual-clock FIFO.
- Sub-module fifo_wrap_ptr:
  - parameter DEPTH; ports clk_i, rst_i, inc_i, ptr_o;
  - wraps at DEPTH-1;
  - instantiated twice, for write and read.
- Top level holds memory, count register, flag decode, error registers and the FWFT/standard output mux, selected by a generate on FWFT.

## Test plan
- Fill, DEPTH = 12, AF_TH = 10, AE_TH = 2: 12 writes of 0x01..0x0C.
  - almost_empty_o falls after write 3; almost_full_o rises after write 10; full_o and count_o = 12 after write 12.
  - A 13th write gives a wr_error_o pulse, count stays 12.
- Drain, standard mode: read the 12 words.
  - rdata_o = 0x01..0x0C, each one cycle after its rd_en_i.
  - empty_o rises after read 12; a 13th read gives a rd_error_o pulse and rdata_o holds 0x0C.
- Wrap-around, DEPTH = 12: write 8, read 8, then write 12 and read 12.
  - Order is preserved across pointer wrap; count_o never exceeds 12.
- Simultaneous access:
  - at full, read + write of 0xAA: both accepted, count stays 12, 0xAA is read last;
  - at empty, read + write of 0x55: rd_error_o pulses, count becomes 1.
- FWFT = 1: write 0x3C into an empty FIFO.
  - rdata_o = 0x3C with empty_o = 0 in the next cycle, with no rd_en_i.
  - A pop gives rdata_o = 0 and empty_o = 1.
- Reset mid-burst: assert rst_i after 5 of 10 writes with rd_en_i high.
  - Next cycle: count_o = 0, empty_o = 1, all other outputs at reset values.
  - A subsequent write/read round-trips correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: ceiling-log2 helper and read-mode selectors,
// common to the single- and dual-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Smallest r with 2**r >= value; loop bound keeps it elaboration-friendly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: increments on inc_i, wraps from DEPTH-1 to 0,
// no power-of-two assumption.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PW   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      ptr_o <= '0;
    else if (inc_i)
      ptr_o <= (ptr_o == PW'(DEPTH - 1)) ? '0 : ptr_o + PW'(1);
  end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with fill count, almost-full/empty
// thresholds, registered error pulses and standard or FWFT read mode.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = 14,
  parameter int AE_TH = 2,
  parameter int FWFT  = FIFO_MODE_STD,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             wr_error_o,
  output logic             rd_error_o
);

  localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             rd_acc, wr_acc;

  // A pop frees a slot in the same edge, so a full FIFO still takes a write.
  assign rd_acc = rd_en_i & (count != '0);
  assign wr_acc = wr_en_i & ((count != CNT_W'(DEPTH)) | rd_acc);

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (wr_acc),
    .ptr_o (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rd_acc),
    .ptr_o (rd_ptr)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc)
      mem[wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count      <= '0;
      wr_error_o <= 1'b0;
      rd_error_o <= 1'b0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      wr_error_o <= wr_en_i & ~wr_acc;
      rd_error_o <= rd_en_i & ~rd_acc;
    end
  end

  assign count_o        = count;
  assign full_o         = (count == CNT_W'(DEPTH));
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= CNT_W'(AF_TH));
  assign almost_empty_o = (count <= CNT_W'(AE_TH));

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rdata_o = empty_o ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk_i) begin
        if (rst_i)
          rdata_q <= '0;
        else if (rd_acc)
          rdata_q <= mem[rd_ptr];
      end
      assign rdata_o = rdata_q;
    end
  endgenerate

endmodule
